// File: rtl/uart_rx_sampler_if.sv
// Downstream side of the UART receive sampler: bit stream toward an external SIPO
// plus frame status pulses.
interface uart_rx_sampler_if;
    logic serial_out;
    logic shift;
    logic frame_done;
    logic frame_err;
    logic busy;

    modport master (
        output serial_out,
        output shift,
        output frame_done,
        output frame_err,
        output busy
    );

    modport slave (
        input serial_out,
        input shift,
        input frame_done,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front end: finds the start bit, samples each data bit
// at its centre and hands it to a downstream SIPO one shift pulse at a time.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                baud_tick,
    uart_rx_sampler_if.master   sipo
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idx, idx_n;
    logic            rx_meta, rx_s, rx_prev;
    logic            vld_meta, vld_s;
    logic            serial_q, serial_n;
    logic            shift_q, shift_n;
    logic            done_q, done_n;
    logic            err_q, err_n;

    // rx_prev only takes real line data once the synchronizer has flushed its
    // reset value, so a line held low through reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            vld_meta <= 1'b0;
            vld_s    <= 1'b0;
            rx_prev  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            vld_meta <= 1'b1;
            vld_s    <= vld_meta;
            rx_prev  <= vld_s & rx_s;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            serial_q <= 1'b1;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            serial_q <= serial_n;
            shift_q  <= shift_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        serial_n = serial_q;
        shift_n  = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (cnt == CNT_HALF) begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    // Power-of-two counter wraps from CNT_LAST to zero by itself.
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        serial_n = rx_s;
                        shift_n  = 1'b1;
                        idx_n    = idx + 1'b1;
                        if (idx == IDX_LAST) state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        done_n  = rx_s;
                        err_n   = !rx_s;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sipo.serial_out = serial_q;
    assign sipo.shift      = shift_q;
    assign sipo.frame_done = done_q;
    assign sipo.frame_err  = err_q;
    assign sipo.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: an event-queue model of each frame
// checked against the DUT on every clk, plus hand-computed pins.
module tb_uart_rx_sampler;
    localparam int OS = 16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic baud_tick;

    uart_rx_sampler_if sipo_if ();

    uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .baud_tick (baud_tick),
        .sipo      (sipo_if.master)
    );

    always #5 clk = ~clk;

    typedef enum {EV_SHIFT, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        logic     bit_val;
        bit       chk_gap;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  ev;
    int   shift_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   tick_div = 1;
    int   tick_ph = 0;
    int   bit_clks = OS;
    int   shift_count = 0;
    int   done_count = 0;
    int   err_count = 0;
    int   last_start_cycle = 0;
    logic exp_serial = 1'b1;
    logic [7:0] sipo_reg = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic bit pending(input ev_kind_t k);
        return exp_q.size() > 0 && exp_q[0].kind == k;
    endfunction

    // Model: a frame yields one shift per data bit in line order, then done or err from the stop bit.
    task automatic push_frame(input logic [7:0] data, input logic stop);
        for (int i = 0; i < DB; i++)
            exp_q.push_back('{kind: EV_SHIFT, bit_val: data[i], chk_gap: (i > 0)});
        exp_q.push_back('{kind: (stop ? EV_DONE : EV_ERR), bit_val: 1'b0, chk_gap: 1'b0});
    endtask

    always @(posedge clk) cycle++;

    initial begin
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick_ph   = (tick_ph + 1) % tick_div;
            baud_tick = (tick_ph == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_serial = 1'b1;
        end else begin
            if (sipo_if.shift || sipo_if.frame_done || sipo_if.frame_err)
                check("one_pulse_only", $countones({sipo_if.shift, sipo_if.frame_done, sipo_if.frame_err}), 1);
            if (sipo_if.shift) begin
                shift_count++;
                shift_log.push_back(cycle);
                sipo_reg = {sipo_if.serial_out, sipo_reg[7:1]};
                check("shift_expected", pending(EV_SHIFT), 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("serial_bit", sipo_if.serial_out, ev.bit_val);
                    if (ev.chk_gap && shift_log.size() > 1)
                        check("shift_gap", cycle - shift_log[shift_log.size()-2], bit_clks);
                    exp_serial = ev.bit_val;
                end
                check("busy_at_shift", sipo_if.busy, 1);
            end else begin
                check("serial_hold", sipo_if.serial_out, exp_serial);
            end
            if (sipo_if.frame_done) begin
                done_count++;
                check("done_expected", pending(EV_DONE), 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                check("busy_after_done", sipo_if.busy, 0);
            end
            if (sipo_if.frame_err) begin
                err_count++;
                check("err_expected", pending(EV_ERR), 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                check("busy_after_err", sipo_if.busy, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        logic [9:0] line;
        line = {stop, data, 1'b0};
        push_frame(data, stop);
        last_start_cycle = cycle;
        for (int i = 0; i < 10; i++) begin
            rx = line[i];
            repeat (bit_clks) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_serial_out"}, sipo_if.serial_out, 1);
        check({tag, "_shift"},      sipo_if.shift, 0);
        check({tag, "_frame_done"}, sipo_if.frame_done, 0);
        check({tag, "_frame_err"},  sipo_if.frame_err, 0);
        check({tag, "_busy"},       sipo_if.busy, 0);
    endtask

    initial begin
        int bs, bd, be;
        logic [9:0] line;
        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(10);

        // Main frame: line bits 1,0,0,0,1,1,1,1 form byte 0xF1 LSB first.
        bs = shift_count; bd = done_count; shift_log.delete();
        send_frame(8'hF1, 1'b1);
        wait_drained("frame1_drained", 200);
        check("frame1_shifts", shift_count - bs, 8);
        check("frame1_done", done_count - bd, 1);
        check("frame1_byte", sipo_reg, 8'hF1);
        // Edge lands 2 clk through the synchronizer, +1 to START, +8 to DATA, +16 to first sample.
        check("first_shift_latency", shift_log[0] - last_start_cycle, 27);

        // Glitch: 4 baud ticks low is shorter than half a bit.
        idle(10);
        bs = shift_count;
        rx = 1'b0;
        idle(4);
        check("glitch_busy_high", sipo_if.busy, 1);
        rx = 1'b1;
        idle(30);
        check("glitch_busy_low", sipo_if.busy, 0);
        check("glitch_no_shift", shift_count - bs, 0);

        // Stop bit low, line stays low afterwards.
        bs = shift_count; bd = done_count; be = err_count;
        send_frame(8'hA5, 1'b0);
        wait_drained("err_drained", 200);
        check("err_shifts", shift_count - bs, 8);
        check("err_pulse", err_count - be, 1);
        check("err_no_done", done_count - bd, 0);
        idle(200);
        check("err_no_rearm_shift", shift_count - bs, 8);
        check("err_idle_busy", sipo_if.busy, 0);
        rx = 1'b1;
        idle(20);
        bd = done_count;
        send_frame(8'h3C, 1'b1);
        wait_drained("rearm_drained", 200);
        check("rearm_done", done_count - bd, 1);
        check("rearm_byte", sipo_reg, 8'h3C);

        // Reset after the third shift, with the line held low through release.
        idle(10);
        bs = shift_count; bd = done_count; be = err_count;
        push_frame(8'h07, 1'b1);
        line = {1'b1, 8'h07, 1'b0};
        for (int i = 0; i < 10 && shift_count - bs < 3; i++) begin
            rx = line[i];
            for (int k = 0; k < bit_clks && shift_count - bs < 3; k++) begin
                @(posedge clk);
                #1;
            end
        end
        check("abort_at_third_shift", shift_count - bs, 3);
        #2;
        rst = 1'b1;
        rx  = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        idle(5);
        rst = 1'b0;
        idle(150);
        check("post_reset_no_shift", shift_count - bs, 3);
        check("post_reset_no_done", done_count - bd, 0);
        check("post_reset_no_err", err_count - be, 0);
        check("post_reset_busy", sipo_if.busy, 0);
        rx = 1'b1;
        idle(20);

        // Back-to-back frames with no idle gap.
        bs = shift_count; bd = done_count;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        wait_drained("b2b_drained", 200);
        check("b2b_shifts", shift_count - bs, 16);
        check("b2b_done", done_count - bd, 2);
        check("b2b_byte", sipo_reg, 8'hAA);

        // Slow tick: one baud_tick every 4 clk gives a 64-clk bit.
        tick_div = 4;
        bit_clks = 4 * OS;
        idle(20);
        bs = shift_count; bd = done_count; shift_log.delete();
        send_frame(8'hF1, 1'b1);
        wait_drained("slow_drained", 400);
        check("slow_shifts", shift_count - bs, 8);
        check("slow_done", done_count - bd, 1);
        check("slow_byte", sipo_reg, 8'hF1);
        if (shift_log.size() >= 2)
            check("slow_gap_literal", shift_log[1] - shift_log[0], 64);
        else
            check("slow_gap_present", shift_log.size(), 8);
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit period (power of two, minimum 8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous UART line, idle high.
REQ-006 The block SHALL have port baud_tick, input, 1 bit: single-clk enable at OVERSAMPLE times the baud rate.
REQ-007 The block SHALL have port serial_out, output, 1 bit: sampled data bit presented to the downstream 8-bit SIPO serial input.
REQ-008 The block SHALL have port shift, output, 1 bit: one-clk pulse; the downstream SIPO captures serial_out when it is high.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-clk pulse; a valid stop bit was received, and the SIPO holds the complete byte.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-clk pulse; the stop bit sampled low.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer, giving rx_s; all decisions use rx_s, which adds 2 clk of latency.
REQ-013 The block SHALL implement the states IDLE, START, DATA and STOP, with a log2(OVERSAMPLE)-bit tick counter cnt and a bit index idx.
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0), detected on any clk regardless of baud_tick, the block SHALL go to START with cnt=0.
REQ-015 IDLE SHALL NOT re-trigger on a line held low; a new start requires a 1->0 transition.
REQ-016 START: cnt SHALL increment on each baud_tick.
REQ-017 START: on the baud_tick where cnt==OVERSAMPLE/2-1, if rx_s==0 the block SHALL go to DATA with cnt=0 and idx=0; otherwise it SHALL treat the event as a false start and return to IDLE with no output pulse.
REQ-018 DATA: on the baud_tick where cnt==OVERSAMPLE-1, the block SHALL register serial_out<=rx_s and pulse shift for exactly one clk, then set cnt=0 and increment idx.
REQ-019 DATA: after the DATA_BITS-th sample the block SHALL go to STOP.
REQ-020 STOP: on the baud_tick where cnt==OVERSAMPLE-1, if rx_s==1 the block SHALL pulse frame_done, otherwise it SHALL pulse frame_err; in both cases it SHALL return to IDLE.
REQ-021 All pulses SHALL be registered and appear in the clk cycle after the qualifying baud_tick edge; shift, frame_done and frame_err SHALL never be high together.
REQ-022 Bits SHALL be forwarded in line order (first data bit first); exactly DATA_BITS shift pulses SHALL occur per accepted frame.
REQ-023 When baud_tick stays low, all counters SHALL hold; serial_out SHALL hold its last value between shift pulses.
REQ-024 On a frame error the block SHALL re-arm only after rx_s returns high and then falls again.
REQ-025 cnt SHALL wrap from OVERSAMPLE-1 to 0 with no extra cycle.

Reset
REQ-026 While rst=1 the block SHALL hold state=IDLE, cnt=0, idx=0, serial_out=1, shift=0, frame_done=0, frame_err=0, busy=0 and both synchronizer flops=1, independent of clk.
REQ-027 When rst asserts mid-frame the block SHALL abort immediately with no further pulses; after release, a line still low SHALL NOT start a frame (REQ-015).

Verification
REQ-028 With baud_tick=1 every clk and OVERSAMPLE=16, the bench SHALL drive a frame of start 0, data 1,0,0,0,1,1,1,1, stop 1 at 16 clk per bit, and SHALL check 8 shift pulses spaced 16 clk apart with serial_out=1,0,0,0,1,1,1,1, a frame_done pulse, and the SIPO reading the expected byte.
REQ-029 The bench SHALL drive rx low for 4 baud periods then high (a glitch) and SHALL check a return to IDLE, no shift pulses, and busy deasserted.
REQ-030 The bench SHALL drive a frame with stop bit 0 and the line held low afterwards, and SHALL check 8 shift pulses, one frame_err pulse, no frame_done, and no new frame until rx rises then falls.
REQ-031 The bench SHALL assert rst after the 3rd shift pulse, and SHALL check that all outputs reach their reset values asynchronously and that no further shift or frame pulses occur.
REQ-032 The bench SHALL drive two back-to-back frames (0x55 then 0xAA) with no idle gap, and SHALL check 16 shift pulses and 2 frame_done pulses.
REQ-033 The bench SHALL run with baud_tick asserted every 4th clk and a 64-clk bit period, and SHALL check shift spacing of 64 clk and identical data results.
